// File: rtl/mux_pack_pkg.sv
// Shared types and helpers for the parametrised beat-to-word packer.
package mux_pack_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        FLUSH = 1'b1
    } pack_state_e;

    // Lane that receives beat index i of a word.
    function automatic int lane_of(input int i, input int ratio, input bit msb_first);
        return msb_first ? (ratio - 1 - i) : i;
    endfunction

    function automatic int out_w_of(input int in_w, input int ratio);
        return in_w * ratio;
    endfunction

endpackage

// File: rtl/pack_out_reg.sv
// Single-entry output holding register: a loaded word and its lane mask stay
// stable until the consumer takes them.
module pack_out_reg #(
    parameter int W = 32,
    parameter int M = 4
) (
    input  logic         clk_4f,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic [M-1:0] load_mask,
    input  logic         ready_out,
    output logic         valid_out,
    output logic [W-1:0] data_out,
    output logic [M-1:0] lane_mask,
    output logic         can_load
);

    // Empty now, or the held word leaves at this edge.
    assign can_load = !valid_out || ready_out;

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            lane_mask <= '0;
        end else if (load) begin
            valid_out <= 1'b1;
            data_out  <= load_data;
            lane_mask <= load_mask;
        end else if (ready_out) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: rtl/mux_pack_param.sv
// Packs RATIO consecutive IN_W-bit beats into one word, with configurable lane
// order and optional zero-padded flush of partial words on an input gap.
module mux_pack_param
    import mux_pack_pkg::*;
#(
    parameter int IN_W          = 8,
    parameter int RATIO         = 4,
    parameter int MSB_FIRST     = 1,
    parameter int FLUSH_PARTIAL = 1,
    localparam int OUT_W        = out_w_of(IN_W, RATIO)
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic [IN_W-1:0]   data_in,
    input  logic              valid_in,
    output logic              ready_in,
    output logic [OUT_W-1:0]  data_out,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [RATIO-1:0]  lane_mask,
    output pack_state_e       state_dbg
);

    localparam int CW = $clog2(RATIO);
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    pack_state_e      state;
    logic [CW-1:0]    count;
    logic [OUT_W-1:0] acc;
    logic [RATIO-1:0] acc_mask;

    logic [OUT_W-1:0] word_nxt;
    logic [RATIO-1:0] mask_nxt;
    int               beat_lane;
    logic             beat_acc;
    logic             complete;
    logic             flush_go;
    logic             gap_flush;
    logic             can_load;
    logic             load;

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; a source holds valid and its payload stable until then, and
    // ready never waits on valid.
    assign ready_in  = (state == ACCUM) && !(count == LAST && valid_out && !ready_out);
    assign beat_acc  = valid_in && ready_in;
    assign complete  = beat_acc && (count == LAST);
    assign flush_go  = (state == FLUSH) && can_load;
    assign gap_flush = (FLUSH_PARTIAL != 0) && (count != '0) && !valid_in;
    assign load      = complete || flush_go;
    assign state_dbg = state;

    always_comb begin
        beat_lane = lane_of(int'(count), RATIO, MSB_FIRST != 0);
        word_nxt  = acc;
        mask_nxt  = acc_mask;
        for (int k = 0; k < RATIO; k++) begin
            if (k == beat_lane) begin
                word_nxt[k*IN_W +: IN_W] = data_in;
                mask_nxt[k]              = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state    <= ACCUM;
            count    <= '0;
            acc      <= '0;
            acc_mask <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (complete) begin
                        count    <= '0;
                        acc      <= '0;
                        acc_mask <= '0;
                    end else if (beat_acc) begin
                        count    <= count + 1'b1;
                        acc      <= word_nxt;
                        acc_mask <= mask_nxt;
                    end else if (gap_flush) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Partial word waits here until the output slot frees up.
                    if (can_load) begin
                        state    <= ACCUM;
                        count    <= '0;
                        acc      <= '0;
                        acc_mask <= '0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    pack_out_reg #(
        .W(OUT_W),
        .M(RATIO)
    ) u_out (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .load      (load),
        .load_data (complete ? word_nxt : acc),
        .load_mask (complete ? mask_nxt : acc_mask),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .lane_mask (lane_mask),
        .can_load  (can_load)
    );

endmodule

// File: tb/tb_mux_pack_param.sv
// Directed bench for mux_pack_param: a vector table on the default build plus
// short sequences on an LSB-first/no-flush build and a 4-bit x 3 build.
module tb_mux_pack_param;
    import mux_pack_pkg::*;

    logic clk_4f = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_4f = ~clk_4f;

    // Default build
    logic        vin_a = 1'b0, rout_a = 1'b1, rdy_a, vout_a;
    logic [7:0]  din_a = '0;
    logic [31:0] dout_a;
    logic [3:0]  mask_a;
    pack_state_e st_a;

    // MSB_FIRST=0, FLUSH_PARTIAL=0
    logic        vin_b = 1'b0, rout_b = 1'b1, rdy_b, vout_b;
    logic [7:0]  din_b = '0;
    logic [31:0] dout_b;
    logic [3:0]  mask_b;
    pack_state_e st_b;

    // IN_W=4, RATIO=3
    logic        vin_c = 1'b0, rout_c = 1'b1, rdy_c, vout_c;
    logic [3:0]  din_c = '0;
    logic [11:0] dout_c;
    logic [2:0]  mask_c;
    pack_state_e st_c;

    mux_pack_param u_a (
        .clk_4f(clk_4f), .reset(reset), .data_in(din_a), .valid_in(vin_a),
        .ready_in(rdy_a), .data_out(dout_a), .valid_out(vout_a),
        .ready_out(rout_a), .lane_mask(mask_a), .state_dbg(st_a)
    );

    mux_pack_param #(.IN_W(8), .RATIO(4), .MSB_FIRST(0), .FLUSH_PARTIAL(0)) u_b (
        .clk_4f(clk_4f), .reset(reset), .data_in(din_b), .valid_in(vin_b),
        .ready_in(rdy_b), .data_out(dout_b), .valid_out(vout_b),
        .ready_out(rout_b), .lane_mask(mask_b), .state_dbg(st_b)
    );

    mux_pack_param #(.IN_W(4), .RATIO(3), .MSB_FIRST(1), .FLUSH_PARTIAL(1)) u_c (
        .clk_4f(clk_4f), .reset(reset), .data_in(din_c), .valid_in(vin_c),
        .ready_in(rdy_c), .data_out(dout_c), .valid_out(vout_c),
        .ready_out(rout_c), .lane_mask(mask_c), .state_dbg(st_c)
    );

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        ro;
        logic        rdy;
        logic        vo;
        logic [31:0] dout;
        logic [3:0]  m;
        logic        fl;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic tick();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic chk(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s %s: got %0h expected %0h", tag, what, act, exp);
        end
    endtask

    task automatic add(input int v, input int d, input int ro, input int rdy,
                       input int vo, input logic [31:0] dout, input int m, input int fl);
        vec_t e;
        e.v    = (v != 0);
        e.d    = 8'(d);
        e.ro   = (ro != 0);
        e.rdy  = (rdy != 0);
        e.vo   = (vo != 0);
        e.dout = dout;
        e.m    = 4'(m);
        e.fl   = (fl != 0);
        tbl.push_back(e);
    endtask

    // One cycle on u_a: ready_in is checked before the edge, registered outputs after it.
    task automatic cyc_a(input vec_t e, input string tag);
        vin_a  = e.v;
        din_a  = e.d;
        rout_a = e.ro;
        #1;
        chk(tag, "ready_in", 32'(rdy_a), 32'(e.rdy));
        tick();
        chk(tag, "valid_out", 32'(vout_a), 32'(e.vo));
        chk(tag, "data_out", dout_a, e.dout);
        chk(tag, "lane_mask", 32'(mask_a), 32'(e.m));
        chk(tag, "in_flush", 32'(st_a == FLUSH), 32'(e.fl));
    endtask

    task automatic cyc_b(input logic v, input logic [7:0] d, input logic e_rdy,
                         input logic e_vo, input logic [31:0] e_do, input logic [3:0] e_m,
                         input string tag);
        vin_b = v;
        din_b = d;
        #1;
        chk(tag, "ready_in", 32'(rdy_b), 32'(e_rdy));
        tick();
        chk(tag, "valid_out", 32'(vout_b), 32'(e_vo));
        chk(tag, "data_out", dout_b, e_do);
        chk(tag, "lane_mask", 32'(mask_b), 32'(e_m));
        chk(tag, "in_flush", 32'(st_b == FLUSH), 32'd0);
    endtask

    task automatic cyc_c(input logic v, input logic [3:0] d, input logic e_rdy,
                         input logic e_vo, input logic [11:0] e_do, input logic [2:0] e_m,
                         input logic e_fl, input string tag);
        vin_c = v;
        din_c = d;
        #1;
        chk(tag, "ready_in", 32'(rdy_c), 32'(e_rdy));
        tick();
        chk(tag, "valid_out", 32'(vout_c), 32'(e_vo));
        chk(tag, "data_out", 32'(dout_c), 32'(e_do));
        chk(tag, "lane_mask", 32'(mask_c), 32'(e_m));
        chk(tag, "in_flush", 32'(st_c == FLUSH), 32'(e_fl));
    endtask

    initial begin
        vec_t e;

        // Fields: v, d, ready_out | exp ready_in, valid_out, data_out, lane_mask, in FLUSH
        add(1, 'hAA, 1,  1, 0, 'h0,        'h0, 0);
        add(1, 'hBB, 1,  1, 0, 'h0,        'h0, 0);
        add(1, 'hCC, 1,  1, 0, 'h0,        'h0, 0);
        add(1, 'hDD, 1,  1, 1, 'hAABBCCDD, 'hF, 0);
        add(1, 'h01, 1,  1, 0, 'hAABBCCDD, 'hF, 0);
        add(1, 'h02, 1,  1, 0, 'hAABBCCDD, 'hF, 0);
        add(1, 'h03, 1,  1, 0, 'hAABBCCDD, 'hF, 0);
        add(1, 'h04, 1,  1, 1, 'h01020304, 'hF, 0);
        add(1, 'h05, 1,  1, 0, 'h01020304, 'hF, 0);
        add(1, 'h06, 1,  1, 0, 'h01020304, 'hF, 0);
        add(1, 'h07, 1,  1, 0, 'h01020304, 'hF, 0);
        add(1, 'h08, 1,  1, 1, 'h05060708, 'hF, 0);
        add(1, 'h11, 1,  1, 0, 'h05060708, 'hF, 0);
        add(1, 'h22, 1,  1, 0, 'h05060708, 'hF, 0);
        add(0, 'hEE, 1,  1, 0, 'h05060708, 'hF, 1);
        add(0, 'h00, 1,  0, 1, 'h11220000, 'hC, 0);
        add(0, 'h00, 1,  1, 0, 'h11220000, 'hC, 0);
        add(1, 'h31, 0,  1, 0, 'h11220000, 'hC, 0);
        add(1, 'h32, 0,  1, 0, 'h11220000, 'hC, 0);
        add(1, 'h33, 0,  1, 0, 'h11220000, 'hC, 0);
        add(1, 'h34, 0,  1, 1, 'h31323334, 'hF, 0);
        add(1, 'h41, 0,  1, 1, 'h31323334, 'hF, 0);
        add(1, 'h42, 0,  1, 1, 'h31323334, 'hF, 0);
        add(1, 'h43, 0,  1, 1, 'h31323334, 'hF, 0);
        add(1, 'h44, 0,  0, 1, 'h31323334, 'hF, 0);
        add(1, 'h44, 0,  0, 1, 'h31323334, 'hF, 0);
        add(1, 'h44, 1,  1, 1, 'h41424344, 'hF, 0);
        add(0, 'h00, 1,  1, 0, 'h41424344, 'hF, 0);
        add(1, 'h61, 0,  1, 0, 'h41424344, 'hF, 0);
        add(1, 'h62, 0,  1, 0, 'h41424344, 'hF, 0);
        add(1, 'h63, 0,  1, 0, 'h41424344, 'hF, 0);
        add(1, 'h64, 0,  1, 1, 'h61626364, 'hF, 0);
        add(1, 'h71, 0,  1, 1, 'h61626364, 'hF, 0);
        add(0, 'h00, 0,  1, 1, 'h61626364, 'hF, 1);
        add(0, 'h00, 0,  0, 1, 'h61626364, 'hF, 1);
        add(0, 'h00, 1,  0, 1, 'h71000000, 'h8, 0);
        add(0, 'h00, 1,  1, 0, 'h71000000, 'h8, 0);

        // Reset with beats offered: nothing may be captured.
        vin_a = 1'b1;
        din_a = 8'h77;
        repeat (3) tick();
        chk("reset", "valid_out", 32'(vout_a), 32'd0);
        chk("reset", "data_out", dout_a, 32'd0);
        chk("reset", "lane_mask", 32'(mask_a), 32'd0);
        chk("reset", "in_flush", 32'(st_a == FLUSH), 32'd0);
        reset = 1'b0;
        vin_a = 1'b0;

        foreach (tbl[i]) cyc_a(tbl[i], $sformatf("vec%0d", i));

        // Reset while holding a full word and a partial word discards both.
        add(1, 'h81, 0,  1, 0, 'h71000000, 'h8, 0);
        add(1, 'h82, 0,  1, 0, 'h71000000, 'h8, 0);
        add(1, 'h83, 0,  1, 0, 'h71000000, 'h8, 0);
        add(1, 'h84, 0,  1, 1, 'h81828384, 'hF, 0);
        add(1, 'h91, 0,  1, 1, 'h81828384, 'hF, 0);
        add(1, 'h92, 0,  1, 1, 'h81828384, 'hF, 0);
        for (int i = 37; i < 43; i++) cyc_a(tbl[i], $sformatf("prerst%0d", i - 37));
        vin_a = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst", "valid_out", 32'(vout_a), 32'd0);
        chk("midrst", "data_out", dout_a, 32'd0);
        chk("midrst", "lane_mask", 32'(mask_a), 32'd0);
        add(1, 'h5A, 1,  1, 0, 'h0,        'h0, 0);
        add(1, 'h5B, 1,  1, 0, 'h0,        'h0, 0);
        add(1, 'h5C, 1,  1, 0, 'h0,        'h0, 0);
        add(1, 'h5D, 1,  1, 1, 'h5A5B5C5D, 'hF, 0);
        add(0, 'h00, 1,  1, 0, 'h5A5B5C5D, 'hF, 0);
        for (int i = 43; i < 48; i++) cyc_a(tbl[i], $sformatf("postrst%0d", i - 43));

        // LSB-first, no flush: count survives a long gap.
        cyc_b(1'b1, 8'hAA, 1'b1, 1'b0, 32'h0, 4'h0, "b_aa");
        cyc_b(1'b1, 8'hBB, 1'b1, 1'b0, 32'h0, 4'h0, "b_bb");
        for (int i = 0; i < 5; i++)
            cyc_b(1'b0, 8'h33, 1'b1, 1'b0, 32'h0, 4'h0, $sformatf("b_gap%0d", i));
        cyc_b(1'b1, 8'hCC, 1'b1, 1'b0, 32'h0, 4'h0, "b_cc");
        cyc_b(1'b1, 8'hDD, 1'b1, 1'b1, 32'hDDCCBBAA, 4'hF, "b_dd");
        cyc_b(1'b0, 8'h00, 1'b1, 1'b0, 32'hDDCCBBAA, 4'hF, "b_idle");

        // 4-bit beats, 3 per word, then a single-beat flush.
        cyc_c(1'b1, 4'h1, 1'b1, 1'b0, 12'h0,   3'b000, 1'b0, "c_1");
        cyc_c(1'b1, 4'h2, 1'b1, 1'b0, 12'h0,   3'b000, 1'b0, "c_2");
        cyc_c(1'b1, 4'h3, 1'b1, 1'b1, 12'h123, 3'b111, 1'b0, "c_3");
        cyc_c(1'b1, 4'h5, 1'b1, 1'b0, 12'h123, 3'b111, 1'b0, "c_5");
        cyc_c(1'b0, 4'h0, 1'b1, 1'b0, 12'h123, 3'b111, 1'b1, "c_gap");
        cyc_c(1'b0, 4'h0, 1'b0, 1'b1, 12'h500, 3'b100, 1'b0, "c_flush");
        cyc_c(1'b0, 4'h0, 1'b1, 1'b0, 12'h500, 3'b100, 1'b0, "c_idle");

        e = tbl[0];
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
